// File: rtl/pipeline_ctrl.sv
`timescale 1ns/1ps
// Hazard/sequencing controller for the 5-stage pipe: stalls and EX redirect are combinational, valids/FSM update on the clock.
// A busy MEM stage freezes every stage; a trap/mret commit redirects the PC one cycle later via REDIR.
module pipeline_ctrl #(
  parameter int Xlen = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            if_valid_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic            id_uses_rs1_i,
  input  logic            id_uses_rs2_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic            ex_is_load_i,
  input  logic            ex_redirect_i,
  input  logic [Xlen-1:0] ex_target_i,
  input  logic            mem_busy_i,
  input  logic            mem_trap_i,
  input  logic            mem_mret_i,
  input  logic [Xlen-1:0] trap_vector_i,
  input  logic [Xlen-1:0] mepc_i,
  output logic            stall_if_o,
  output logic            stall_id_o,
  output logic            stall_ex_o,
  output logic            stall_mem_o,
  output logic            id_valid_o,
  output logic            ex_valid_o,
  output logic            mem_valid_o,
  output logic            wb_valid_o,
  output logic            pc_redirect_o,
  output logic [Xlen-1:0] pc_target_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    REDIR = 2'b01
  } state_t;

  state_t          state_q, state_d;
  logic            id_valid_q, ex_valid_q, mem_valid_q, wb_valid_q;
  logic            id_valid_d, ex_valid_d, mem_valid_d, wb_valid_d;
  logic [Xlen-1:0] target_q, target_d;

  logic in_redir, commit, mem_stall, ex_redir, hazard, load_use;

  // Event detection in priority order: commit > mem stall > EX redirect > load-use.
  always_comb begin
    in_redir  = (state_q == REDIR);
    commit    = mem_valid_q & (mem_trap_i | mem_mret_i) & ~mem_busy_i;
    mem_stall = mem_busy_i & mem_valid_q;
    ex_redir  = ex_redirect_i & ex_valid_q & ~mem_stall & ~commit & ~in_redir;
    hazard    = ex_valid_q & ex_is_load_i & (ex_rd_addr_i != 5'd0) & id_valid_q &
                ((id_uses_rs1_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                 (id_uses_rs2_i & (id_rs2_addr_i == ex_rd_addr_i)));
    load_use  = hazard & ~mem_stall & ~commit & ~ex_redir & ~in_redir;
  end

  always_comb begin
    state_d     = RUN;
    target_d    = target_q;
    id_valid_d  = if_valid_i;
    ex_valid_d  = id_valid_q;
    mem_valid_d = ex_valid_q;
    wb_valid_d  = mem_valid_q;

    stall_if_o    = mem_stall | load_use;
    stall_id_o    = mem_stall | load_use;
    stall_ex_o    = mem_stall;
    stall_mem_o   = mem_stall;
    pc_redirect_o = in_redir | ex_redir;
    pc_target_o   = '0;
    busy_o        = (state_q != RUN);

    if (in_redir) begin
      pc_target_o = target_q;
    end else if (ex_redir) begin
      pc_target_o = ex_target_i;
    end

    if (commit) begin
      // Committing instruction retires into WB; everything younger is squashed.
      id_valid_d  = 1'b0;
      ex_valid_d  = 1'b0;
      mem_valid_d = 1'b0;
      wb_valid_d  = 1'b1;
      target_d    = mem_trap_i ? trap_vector_i : mepc_i;
    end else if (mem_stall) begin
      id_valid_d  = id_valid_q;
      ex_valid_d  = ex_valid_q;
      mem_valid_d = mem_valid_q;
      wb_valid_d  = 1'b0;
    end else if (in_redir) begin
      id_valid_d  = 1'b0;
    end else if (ex_redir) begin
      id_valid_d  = 1'b0;
      ex_valid_d  = 1'b0;
    end else if (load_use) begin
      id_valid_d  = id_valid_q;
      ex_valid_d  = 1'b0;
    end

    unique case (state_q)
      RUN:     state_d = commit ? REDIR : RUN;
      REDIR:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      target_q    <= '0;
      id_valid_q  <= 1'b0;
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      id_valid_q  <= id_valid_d;
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
    end
  end

  assign id_valid_o  = id_valid_q;
  assign ex_valid_o  = ex_valid_q;
  assign mem_valid_o = mem_valid_q;
  assign wb_valid_o  = wb_valid_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
`timescale 1ns/1ps
// Directed bench for pipeline_ctrl: hand-computed expectations for valids, stalls, redirects and reset.
module tb_pipeline_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_valid_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
  logic        id_uses_rs1_i, id_uses_rs2_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_is_load_i, ex_redirect_i;
  logic [31:0] ex_target_i;
  logic        mem_busy_i, mem_trap_i, mem_mret_i;
  logic [31:0] trap_vector_i, mepc_i;
  logic        stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
  logic        id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o;
  logic        pc_redirect_o;
  logic [31:0] pc_target_o;
  logic        busy_o;

  logic [3:0] vld, stl;
  assign vld = {id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o};
  assign stl = {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o};

  int checks = 0;
  int failures = 0;

  pipeline_ctrl #(.Xlen(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .if_valid_i(if_valid_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_is_load_i(ex_is_load_i),
    .ex_redirect_i(ex_redirect_i), .ex_target_i(ex_target_i),
    .mem_busy_i(mem_busy_i), .mem_trap_i(mem_trap_i), .mem_mret_i(mem_mret_i),
    .trap_vector_i(trap_vector_i), .mepc_i(mepc_i),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
    .stall_ex_o(stall_ex_o), .stall_mem_o(stall_mem_o),
    .id_valid_o(id_valid_o), .ex_valid_o(ex_valid_o),
    .mem_valid_o(mem_valid_o), .wb_valid_o(wb_valid_o),
    .pc_redirect_o(pc_redirect_o), .pc_target_o(pc_target_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    if_valid_i = 1'b0; id_rs1_addr_i = '0; id_rs2_addr_i = '0;
    id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0; ex_rd_addr_i = '0;
    ex_is_load_i = 1'b0; ex_redirect_i = 1'b0; ex_target_i = '0;
    mem_busy_i = 1'b0; mem_trap_i = 1'b0; mem_mret_i = 1'b0;
  endtask

  task automatic fill();
    if_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    trap_vector_i = 32'h100;
    mepc_i = 32'h2004;
    #2;
    chk("rst_valids", 32'(vld), 32'h0);
    chk("rst_stalls", 32'(stl), 32'h0);
    chk("rst_redirect", 32'(pc_redirect_o), 32'h0);
    chk("rst_target", pc_target_o, 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    #10 rst_ni = 1'b1;
    step();

    fill();
    chk("fill_valids", 32'(vld), 32'hF);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
    ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd5; id_rs1_addr_i = 5'd5;
    id_rs2_addr_i = 5'd1; id_uses_rs1_i = 1'b1; id_uses_rs2_i = 1'b1;
    #1;
    chk("lu_stalls", 32'(stl), 32'hC);
    step();
    ex_is_load_i = 1'b0;
    #1;
    chk("lu_bubble_valids", 32'(vld), 32'hB);
    chk("lu_resume_stalls", 32'(stl), 32'h0);
    fill();
    // rs2 match also stalls
    ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd7; id_rs1_addr_i = 5'd2;
    id_rs2_addr_i = 5'd7; id_uses_rs1_i = 1'b1; id_uses_rs2_i = 1'b1;
    #1;
    chk("lu_rs2_stalls", 32'(stl), 32'hC);
    id_uses_rs2_i = 1'b0;
    #1;
    chk("lu_rs2_unused", 32'(stl), 32'h0);
    ex_rd_addr_i = 5'd0; id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0; id_uses_rs2_i = 1'b1;
    #1;
    chk("lu_x0_stalls", 32'(stl), 32'h0);

    // EX redirect together with a load-use hazard: redirect wins.
    ex_rd_addr_i = 5'd5; id_rs1_addr_i = 5'd5;
    ex_redirect_i = 1'b1; ex_target_i = 32'h80;
    #1;
    chk("exr_redirect", 32'(pc_redirect_o), 32'h1);
    chk("exr_target", pc_target_o, 32'h80);
    chk("exr_stalls", 32'(stl), 32'h0);
    step();
    clear_inputs();
    if_valid_i = 1'b1;
    #1;
    chk("exr_valids", 32'(vld), 32'h3);
    chk("exr_redirect_off", 32'(pc_redirect_o), 32'h0);
    fill();

    // MEM busy for 3 cycles with a branch held in EX.
    mem_busy_i = 1'b1; ex_redirect_i = 1'b1; ex_target_i = 32'h44;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_stalls", 32'(stl), 32'hF);
      chk("busy_no_redirect", 32'(pc_redirect_o), 32'h0);
      step();
      chk("busy_valids", 32'(vld), 32'hE);
    end
    mem_busy_i = 1'b0;
    #1;
    chk("busy_drop_redirect", 32'(pc_redirect_o), 32'h1);
    chk("busy_drop_target", pc_target_o, 32'h44);
    chk("busy_drop_stalls", 32'(stl), 32'h0);
    step();
    clear_inputs();
    if_valid_i = 1'b1;
    step();
    chk("post_busy_valids", 32'(vld), 32'h9);
    mem_busy_i = 1'b1;
    #1;
    chk("busy_ignored", 32'(stl), 32'h0);
    mem_busy_i = 1'b0;
    fill();

    // Trap commit.
    mem_trap_i = 1'b1;
    #1;
    chk("trap_commit_redirect", 32'(pc_redirect_o), 32'h0);
    chk("trap_commit_busy", 32'(busy_o), 32'h0);
    step();
    mem_trap_i = 1'b0;
    #1;
    chk("trap_valids", 32'(vld), 32'h1);
    chk("trap_redirect", 32'(pc_redirect_o), 32'h1);
    chk("trap_target", pc_target_o, 32'h100);
    chk("trap_busy", 32'(busy_o), 32'h1);
    step();
    chk("trap_after_valids", 32'(vld), 32'h0);
    chk("trap_after_busy", 32'(busy_o), 32'h0);
    chk("trap_after_redirect", 32'(pc_redirect_o), 32'h0);

    // mret commit.
    fill();
    mem_mret_i = 1'b1;
    step();
    mem_mret_i = 1'b0;
    #1;
    chk("mret_target", pc_target_o, 32'h2004);
    chk("mret_busy", 32'(busy_o), 32'h1);

    // trap and mret together: trap vector wins.
    fill();
    mem_trap_i = 1'b1; mem_mret_i = 1'b1;
    step();
    mem_trap_i = 1'b0; mem_mret_i = 1'b0;
    #1;
    chk("both_target", pc_target_o, 32'h100);

    // Reset asserted mid-REDIR.
    fill();
    mem_trap_i = 1'b1;
    step();
    mem_trap_i = 1'b0;
    #1;
    chk("pre_rst_busy", 32'(busy_o), 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_redirect", 32'(pc_redirect_o), 32'h0);
    chk("midrst_target", pc_target_o, 32'h0);
    chk("midrst_busy", 32'(busy_o), 32'h0);
    chk("midrst_valids", 32'(vld), 32'h0);
    clear_inputs();
    step();
    rst_ni = 1'b1;
    step();
    chk("postrst_busy", 32'(busy_o), 32'h0);
    chk("postrst_redirect", 32'(pc_redirect_o), 32'h0);
    chk("postrst_valids", 32'(vld), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
